// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction fetch stage.
//   NOP_INSTR     - instruction presented when no valid entry (addi x0,x0,0)
//   fetch_state_e - fetch FSM states
//   if_entry_t    - buffered {pc, instr} pair
package if_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, RESP} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;
endpackage

// File: rtl/if_instr_fifo.sv
// if_instr_fifo: DEPTH-entry buffer of fetched {pc, instr} pairs.
//   i_clk, i_resetn - clock, async active-low reset
//   flush_i         - synchronous flush, wins over push/pop
//   push_i, data_i  - write an entry (caller guarantees not full)
//   pop_i           - drop the head (caller guarantees not empty)
//   valid_o, head_o - head entry and its validity
//   count_o         - number of stored entries
module if_instr_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  if_entry_t              data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output if_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  if_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  // Storage needs no reset: the head is only used while valid_o is high.
  always_ff @(posedge i_clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
  assign valid_o = cnt_q != '0;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I fetch stage; owns the fetch PC, issues one imem request
// at a time and buffers returned words for the IF/ID register.
//   i_clk, i_resetn          - clock, async active-low reset
//   i_stall                  - IF/ID not accepting; head is held
//   i_redirect, i_redirect_pc - taken branch/jump; flushes buffer and in-flight fetch
//   o_imem_req/o_imem_addr   - request and word address, stable until i_imem_gnt
//   i_imem_rvalid/i_imem_rdata - response for the outstanding request
//   o_if_valid/pc/p4/instr   - head entry toward IF/ID
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = if_pkg::NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_p4,
  output logic [31:0] o_if_instr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  fetch_state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic drop_q, drop_d, push, pop, head_valid;
  logic [CW-1:0] count;
  if_entry_t head;
  if_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_resetn(i_resetn),
    .flush_i (i_redirect),
    .push_i  (push),
    .data_i  ('{pc: addr_q, instr: i_imem_rdata}),
    .pop_i   (pop),
    .valid_o (head_valid),
    .head_o  (head),
    .count_o (count)
  );
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
    end
  end
  // fetch_pc_q is the next address to fetch; addr_q is the address of the
  // current/outstanding request, so a redirect can retarget fetch_pc while an
  // ungranted request keeps its address. drop_q set in REQ means a redirect
  // already supplied fetch_pc, so the grant must not advance it.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    push       = 1'b0;
    case (state_q)
      IDLE: state_d = (count < DEPTH_C) ? REQ : IDLE;
      REQ: if (i_imem_gnt) begin
        state_d    = RESP;
        fetch_pc_d = drop_q ? fetch_pc_q : fetch_pc_q + 32'd4;
      end
      RESP: if (i_imem_rvalid) begin
        push    = !drop_q;
        drop_d  = 1'b0;
        state_d = (count + CW'(!drop_q) < DEPTH_C) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc & ~32'h3;
      push       = 1'b0;
      // A response arriving this cycle is the pending one; only mark drop
      // when one is still to come.
      if (state_q == REQ || (state_q == RESP && !i_imem_rvalid)) drop_d = 1'b1;
    end
    addr_d = (state_d == REQ && state_q != REQ) ? fetch_pc_d : addr_q;
  end
  assign pop         = head_valid && !i_stall && !i_redirect;
  assign o_imem_req  = state_q == REQ;
  assign o_imem_addr = addr_q;
  assign o_if_valid  = head_valid;
  assign o_if_pc     = head_valid ? head.pc : 32'h0;
  assign o_if_p4     = head_valid ? head.pc + 32'd4 : 32'h0;
  assign o_if_instr  = head_valid ? head.instr : NOP_INSTR;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit with a one-outstanding
// memory model answering rdata = addr | 0x13 one cycle after grant.
module tb_if_fetch_unit;
  logic i_clk = 1'b0, i_resetn = 1'b0, i_stall = 1'b0, i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0, i_imem_rdata = '0;
  logic i_imem_gnt = 1'b0, i_imem_rvalid = 1'b0;
  logic o_imem_req, o_if_valid;
  logic [31:0] o_imem_addr, o_if_pc, o_if_p4, o_if_instr;
  logic gnt_en = 1'b0, rv_en = 1'b1, pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int nvec = 0, miss = 0;

  if_fetch_unit dut (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_stall(i_stall),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_if_valid(o_if_valid), .o_if_pc(o_if_pc), .o_if_p4(o_if_p4), .o_if_instr(o_if_instr)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory inputs, take the edge, update the model, return at negedge.
  task automatic cyc();
    logic g, rv;
    logic [31:0] a;
    i_imem_gnt    = gnt_en & o_imem_req;
    i_imem_rvalid = pend & rv_en;
    i_imem_rdata  = pend_addr | 32'h13;
    g  = i_imem_gnt;
    rv = i_imem_rvalid;
    a  = o_imem_addr;
    @(posedge i_clk);
    #1;
    if (rv) pend = 1'b0;
    if (g) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    i_redirect = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_resetn = 1'b0;
    i_stall = 1'b0; i_redirect = 1'b0; gnt_en = 1'b0; rv_en = 1'b1; pend = 1'b0;
    cyc(); cyc();
    i_resetn = 1'b1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, ".valid"}, 32'(o_if_valid), 32'd1);
    chk({tag, ".pc"}, o_if_pc, pc);
    chk({tag, ".p4"}, o_if_p4, pc + 32'd4);
    chk({tag, ".instr"}, o_if_instr, instr);
  endtask

  initial begin
    // reset state
    cyc(); cyc();
    chk("rst.req", 32'(o_imem_req), 32'd0);
    chk("rst.valid", 32'(o_if_valid), 32'd0);
    chk("rst.pc", o_if_pc, 32'h0);
    chk("rst.p4", o_if_p4, 32'h0);
    chk("rst.instr", o_if_instr, 32'h13);

    // 1: streaming fetch
    i_resetn = 1'b1; gnt_en = 1'b1;
    cyc();
    chk("t1.req0", 32'(o_imem_req), 32'd1);
    chk("t1.addr0", o_imem_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(); cyc();
      chk_head("t1.head", 32'(4 * k), 32'(4 * k) | 32'h13);
      chk("t1.req", 32'(o_imem_req), 32'd1);
      chk("t1.addr", o_imem_addr, 32'(4 * k + 4));
    end

    // 2: stall fills the buffer, then drains in order
    do_reset();
    i_stall = 1'b1; gnt_en = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("t2.req_blocked", 32'(o_imem_req), 32'd0);
    chk_head("t2.held", 32'h0, 32'h13);
    i_stall = 1'b0;
    cyc();
    chk_head("t2.pop0", 32'h4, 32'h17);
    chk("t2.req_wait", 32'(o_imem_req), 32'd0);
    cyc();
    chk("t2.empty", 32'(o_if_valid), 32'd0);
    chk("t2.req_resume", 32'(o_imem_req), 32'd1);
    chk("t2.addr_resume", o_imem_addr, 32'h8);
    cyc(); cyc();
    chk_head("t2.next", 32'h8, 32'h1b);

    // 3: redirect while waiting for the 0x8 response
    do_reset();
    gnt_en = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    i_stall = 1'b1;
    cyc();
    chk_head("t3.before", 32'h4, 32'h17);
    i_redirect = 1'b1; i_redirect_pc = 32'h103; rv_en = 1'b0;
    cyc();
    chk("t3.flushed", 32'(o_if_valid), 32'd0);
    chk("t3.nop", o_if_instr, 32'h13);
    i_stall = 1'b0; rv_en = 1'b1;
    cyc();
    chk("t3.dropped", 32'(o_if_valid), 32'd0);
    chk("t3.req", 32'(o_imem_req), 32'd1);
    chk("t3.addr", o_imem_addr, 32'h100);
    cyc(); cyc();
    chk_head("t3.target", 32'h100, 32'h113);

    // 4: redirect while the request is not yet granted
    do_reset();
    cyc();
    chk("t4.addr0", o_imem_addr, 32'h0);
    cyc();
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    cyc();
    chk("t4.req_hold", 32'(o_imem_req), 32'd1);
    chk("t4.addr_hold", o_imem_addr, 32'h0);
    cyc();
    chk("t4.addr_hold2", o_imem_addr, 32'h0);
    gnt_en = 1'b1;
    cyc(); cyc();
    chk("t4.dropped", 32'(o_if_valid), 32'd0);
    chk("t4.addr_new", o_imem_addr, 32'h200);
    cyc(); cyc();
    chk_head("t4.target", 32'h200, 32'h213);

    // 5: redirect coincident with rvalid while stalled
    do_reset();
    i_stall = 1'b1; gnt_en = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    chk_head("t5.before", 32'h0, 32'h13);
    chk("t5.pend", 32'(pend), 32'd1);
    i_redirect = 1'b1; i_redirect_pc = 32'h300;
    cyc();
    chk("t5.flushed", 32'(o_if_valid), 32'd0);
    chk("t5.req", 32'(o_imem_req), 32'd0);
    i_stall = 1'b0;
    cyc();
    chk("t5.addr", o_imem_addr, 32'h300);
    cyc(); cyc();
    chk_head("t5.target", 32'h300, 32'h313);

    // 6: reset mid-RESP, stale response afterwards
    do_reset();
    gnt_en = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    chk("t6.pend_addr", pend_addr, 32'h4);
    i_resetn = 1'b0;
    #1;
    chk("t6.async_req", 32'(o_imem_req), 32'd0);
    chk("t6.async_valid", 32'(o_if_valid), 32'd0);
    rv_en = 1'b0; gnt_en = 1'b0;
    cyc();
    i_resetn = 1'b1; rv_en = 1'b1;
    cyc();
    chk("t6.stale_ignored", 32'(o_if_valid), 32'd0);
    chk("t6.instr", o_if_instr, 32'h13);
    chk("t6.req", 32'(o_imem_req), 32'd1);
    chk("t6.addr", o_imem_addr, 32'h0);
    gnt_en = 1'b1;
    cyc(); cyc();
    chk_head("t6.first", 32'h0, 32'h13);

    // 7: redirect in IDLE to the top word, pc wraps to 0
    do_reset();
    gnt_en = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFF;
    cyc();
    chk("t7.addr_top", o_imem_addr, 32'hFFFF_FFFC);
    cyc(); cyc();
    chk("t7.pc", o_if_pc, 32'hFFFF_FFFC);
    chk("t7.p4_wrap", o_if_p4, 32'h0);
    chk("t7.instr", o_if_instr, 32'hFFFF_FFFF);
    chk("t7.addr_wrap", o_imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage of the 5-stage RV32I pipeline. It owns the fetch PC, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned words in a small FIFO. It presents pc, pc+4 and instr to the IF/ID pipeline register, whose write enable is the inverse of i_stall. Branch/jump redirects from EX flush all buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries; power of 2, >=2
NOP_INSTR, 32'h0000_0013, instr driven when no valid entry (addi x0,x0,0)

Ports:
i_clk  in  1  clock
i_resetn  in  1  reset
i_stall  in  1  downstream not accepting this cycle
i_redirect  in  1  taken branch/jump from EX
i_redirect_pc  in  32  redirect target; bits[1:0] ignored and forced to 0
o_imem_req  out  1  fetch request
o_imem_addr  out  32  word-aligned fetch address
i_imem_gnt  in  1  request accepted this cycle
i_imem_rvalid  in  1  response data valid
i_imem_rdata  in  32  response instruction word
o_if_valid  out  1  head entry valid
o_if_pc  out  32  pc of head entry
o_if_p4  out  32  o_if_pc + 4, mod 2^32
o_if_instr  out  32  head instruction, NOP_INSTR when !o_if_valid

Behaviour:
- Reset: i_resetn is asynchronous, active-low; clock is i_clk. During reset: fetch_pc=RESET_PC, FIFO empty, state IDLE, drop=0, o_imem_req=0, o_if_valid=0, o_if_pc=0, o_if_p4=0, o_if_instr=NOP_INSTR. Reset mid-transaction abandons it; rvalid arriving in IDLE is ignored.
- One outstanding transaction maximum.
- FSM:
  - IDLE: if count+0 < FIFO_DEPTH, go to REQ and drive req.
  - REQ: o_imem_req=1, o_imem_addr=fetch_pc. Addr and req stay stable until gnt. On gnt, fetch_pc += 4 and go to RESP.
  - RESP: wait for rvalid. On rvalid, push {pc, rdata} unless drop. If space remains after the push, go directly to REQ (back-to-back issue); otherwise go to IDLE. Clear drop.
- gnt and rvalid may arrive in the same cycle as a new request only if memory permits. Minimum latency is gnt in the req cycle and rvalid one cycle later.
- Issue rule: no new request while count + (state==RESP) >= FIFO_DEPTH.
- Consume: head pops when o_if_valid && !i_stall. Push and pop can occur in the same cycle; count then stays unchanged.
- Output is driven from registered FIFO head. Each word becomes visible the cycle after its rvalid.
- Redirect (highest priority, takes effect at the next edge):
  - FIFO flushed; o_if_valid=0 on the next cycle.
  - fetch_pc = {i_redirect_pc[31:2],2'b00}.
  - If state is REQ (granted or not) or RESP, set drop; the pending response is discarded. Any request still ungranted keeps its old address until gnt.
  - Redirect in the same cycle as rvalid: data dropped.
  - Redirect with i_stall: redirect wins, and the head is not consumed.
  - Redirect in IDLE: the next request uses the new pc.
- fetch_pc wraps 0xFFFF_FFFC -> 0x0000_0000.
- Stall never blocks memory responses. They are buffered because issue is credit-limited.

Decomposition:
- Package if_pkg: NOP_INSTR constant, fetch state enum (IDLE, REQ, RESP), entry struct {pc[31:0], instr[31:0]}.
- Sub-module if_instr_fifo: FIFO_DEPTH x 64 bits, synchronous flush, push/pop, count, head outputs.
- FSM, fetch_pc and drop logic stay in if_fetch_unit.

Test Plan:
1. Reset release, gnt tied 1, rvalid 1 cycle after gnt, rdata=addr|0x13, no stall -> addresses 0,4,8,... on consecutive requests. o_if_valid first high 2 cycles after first req with pc=0, p4=4, instr=0x13.
2. Hold i_stall=1 from start -> exactly 2 words buffered (pc 0,4), then o_imem_req=0. Release stall -> pops pc 0, 4, then fetch resumes at 8 with no gap or duplicate.
3. Redirect to 0x103 while in RESP for addr 0x8 -> response for 0x8 discarded, o_if_valid=0 next cycle. Next request addr=0x100; first valid output pc=0x100, p4=0x104.
4. gnt withheld 3 cycles and redirect to 0x200 on cycle 2 -> o_imem_addr stays at old value until gnt and that response is dropped. The following request is 0x200.
5. Redirect coincident with rvalid and i_stall=1 -> rdata not pushed, FIFO empty, head not consumed. Next valid pc = redirect target.
6. Assert i_resetn=0 in RESP, then inject a stale rvalid after release -> ignored. First request addr=RESET_PC and outputs are at reset values until then.
